// File: rtl/datagram_receiver_pkg.sv
// Shared link constants and receiver state encoding.
// Also used by datagram_transmitter for beat width and ordering.
package datagram_receiver_pkg;

  localparam int MESSAGE_SIZE = 64;
  localparam int LINK_LANE_W  = 8;
  localparam int LINK_TIMEOUT = 1023;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CSUM,
    PEND
  } rx_state_t;

  function automatic int beats_of(int msg_w, int lane_w);
    return (msg_w + lane_w - 1) / lane_w;
  endfunction

endpackage

// File: rtl/datagram_receiver_assembler.sv
// link_beat_assembler: beat index, LSB-first assembly, XOR, idle timer.
// Ports: clk, rst (async low), start/take/beat/busy, data in;
//   asm_data, xor_acc, last, timeout out.
module link_beat_assembler
  import datagram_receiver_pkg::*;
#(
  parameter int MSG_W   = MESSAGE_SIZE,
  parameter int LANE_W  = LINK_LANE_W,
  parameter int TIMEOUT = LINK_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              take,
  input  logic              beat,
  input  logic              busy,
  input  logic [LANE_W-1:0] data,
  output logic [MSG_W-1:0]  asm_data,
  output logic [LANE_W-1:0] xor_acc,
  output logic              last,
  output logic              timeout
);

  localparam int BEATS = beats_of(MSG_W, LANE_W);
  localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(TIMEOUT + 1);

  logic [IW-1:0] idx;
  logic [CW-1:0] idle_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      xor_acc  <= '0;
      asm_data <= '0;
      idle_cnt <= '0;
    end else begin
      if (start) begin
        idx     <= (BEATS > 1) ? IW'(1) : '0;
        xor_acc <= data;
      end else if (take) begin
        idx     <= idx + 1'b1;
        xor_acc <= xor_acc ^ data;
      end
      // Bits of the last beat beyond MSG_W have no home here.
      for (int k = 0; k < MSG_W; k++) begin
        if ((start && k < LANE_W) ||
            (take && idx == IW'(k / LANE_W)))
          asm_data[k] <= data[k % LANE_W];
      end
      if (beat || !busy)
        idle_cnt <= '0;
      else if (idle_cnt != CW'(TIMEOUT))
        idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign last    = (idx == IW'(BEATS - 1));
  assign timeout = busy && !beat &&
                   (idle_cnt == CW'(TIMEOUT));

endmodule

// File: rtl/datagram_receiver.sv
// Rebuilds the datagram from the beat-serial link, XOR-checked.
// Ports: clk, rst (async low), link_valid/sof/data, frame_commit;
//   datagram, datagram_valid, err_count, frame_count out.
// DATAGRAM_RX_VBLANK_COMMIT_EN: hold good frames until frame_commit.
module datagram_receiver
  import datagram_receiver_pkg::*;
#(
  parameter int MSG_W   = MESSAGE_SIZE,
  parameter int LANE_W  = LINK_LANE_W,
  parameter int TIMEOUT = LINK_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              link_valid,
  input  logic              link_sof,
  input  logic [LANE_W-1:0] link_data,
  input  logic              frame_commit,
  output logic [MSG_W-1:0]  datagram,
  output logic              datagram_valid,
  output logic [7:0]        err_count,
  output logic [7:0]        frame_count
);

  localparam int BEATS = beats_of(MSG_W, LANE_W);
  localparam rx_state_t FIRST = (BEATS == 1) ? CSUM : RECV;

  rx_state_t state_q, state_d, rest;

  logic [MSG_W-1:0]  asm_data;
  logic [LANE_W-1:0] xor_acc;
  logic              last, tmo;
  logic              in_frame, sof, take, csum_beat;
  logic              good, abort, commit;
  logic [MSG_W-1:0]  new_dg;

  assign in_frame  = (state_q == RECV) || (state_q == CSUM);
  assign sof       = link_valid && link_sof;
  assign take      = link_valid && !link_sof && (state_q == RECV);
  assign csum_beat = link_valid && !link_sof && (state_q == CSUM);
  assign good      = csum_beat && (link_data == xor_acc);
  assign abort     = in_frame &&
                     (sof || tmo || (csum_beat && !good));

  link_beat_assembler #(
    .MSG_W   (MSG_W),
    .LANE_W  (LANE_W),
    .TIMEOUT (TIMEOUT)
  ) u_asm (
    .clk      (clk),
    .rst      (rst),
    .start    (sof),
    .take     (take),
    .beat     (link_valid),
    .busy     (in_frame),
    .data     (link_data),
    .asm_data (asm_data),
    .xor_acc  (xor_acc),
    .last     (last),
    .timeout  (tmo)
  );

`ifdef DATAGRAM_RX_VBLANK_COMMIT_EN
  logic [MSG_W-1:0] shadow_q;
  logic             pend_q, pend_d;

  // Commit takes the old shadow even if a new frame lands now.
  assign commit = frame_commit && pend_q;
  assign new_dg = shadow_q;
  assign pend_d = good || (pend_q && !commit);
  assign rest   = pend_d ? PEND : IDLE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      if (good)
        shadow_q <= asm_data;
      pend_q <= pend_d;
    end
  end
`else
  logic unused_frame_commit;

  assign unused_frame_commit = frame_commit;
  assign commit = good;
  assign new_dg = asm_data;
  assign rest   = IDLE;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sof) begin
      state_d = FIRST;
    end else begin
      unique case (state_q)
        RECV: begin
          if (tmo)
            state_d = rest;
          else if (take && last)
            state_d = CSUM;
        end
        CSUM: begin
          if (tmo || csum_beat)
            state_d = rest;
        end
        IDLE, PEND: state_d = rest;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      datagram       <= '0;
      datagram_valid <= 1'b0;
      err_count      <= '0;
      frame_count    <= '0;
    end else begin
      if (abort && (err_count != 8'hFF))
        err_count <= err_count + 1'b1;
      if (commit) begin
        datagram       <= new_dg;
        datagram_valid <= 1'b1;
        frame_count    <= frame_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_datagram_receiver.sv
// Directed bench for datagram_receiver (MSG_W=16, LANE_W=8, TIMEOUT=15).
// Table of per-cycle vectors plus hand-written corner sequences.
module tb_datagram_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        link_valid = 1'b0;
  logic        link_sof = 1'b0;
  logic [7:0]  link_data = 8'h00;
  logic        frame_commit = 1'b0;
  logic [15:0] datagram;
  logic        datagram_valid;
  logic [7:0]  err_count;
  logic [7:0]  frame_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  datagram_receiver #(
    .MSG_W   (16),
    .LANE_W  (8),
    .TIMEOUT (15)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .link_valid     (link_valid),
    .link_sof       (link_sof),
    .link_data      (link_data),
    .frame_commit   (frame_commit),
    .datagram       (datagram),
    .datagram_valid (datagram_valid),
    .err_count      (err_count),
    .frame_count    (frame_count)
  );

  typedef struct {
    logic        v;
    logic        s;
    logic [7:0]  d;
    logic [15:0] dg;
    logic        dv;
    logic [7:0]  e;
    logic [7:0]  f;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [15:0] dg,
                         logic dv, logic [7:0] e,
                         logic [7:0] f);
    chk({tag, " datagram"}, 32'(datagram), 32'(dg));
    chk({tag, " valid"}, 32'(datagram_valid), 32'(dv));
    chk({tag, " err_count"}, 32'(err_count), 32'(e));
    chk({tag, " frame_count"}, 32'(frame_count), 32'(f));
  endtask

  task automatic row(logic v, logic s, logic [7:0] d,
                     logic [15:0] dg, logic dv,
                     logic [7:0] e, logic [7:0] f);
    vec_t r;
    r.v = v; r.s = s; r.d = d;
    r.dg = dg; r.dv = dv; r.e = e; r.f = f;
    tbl.push_back(r);
  endtask

  task automatic idle(int n, logic [15:0] dg, logic dv,
                      logic [7:0] e, logic [7:0] f);
    for (int i = 0; i < n; i++)
      row(1'b0, 1'b0, 8'h00, dg, dv, e, f);
  endtask

  // Drive one cycle at negedge; return 1ns after the posedge.
  task automatic beat(logic v, logic s, logic [7:0] d);
    @(negedge clk);
    link_valid = v;
    link_sof   = s;
    link_data  = d;
    @(posedge clk);
    #1;
    link_valid = 1'b0;
    link_sof   = 1'b0;
  endtask

  task automatic frame(logic [7:0] b0, logic [7:0] b1,
                       logic [7:0] c);
    beat(1'b1, 1'b1, b0);
    beat(1'b1, 1'b0, b1);
    beat(1'b1, 1'b0, c);
  endtask

  task automatic commit_pulse();
    @(negedge clk);
    frame_commit = 1'b1;
    @(posedge clk);
    #1;
    frame_commit = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 16'h0, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    rst = 1'b1;

`ifndef DATAGRAM_RX_VBLANK_COMMIT_EN
    // good frame
    row(1, 1, 8'h34, 16'h0000, 0, 0, 0);
    row(1, 0, 8'h12, 16'h0000, 0, 0, 0);
    row(1, 0, 8'h26, 16'h1234, 1, 0, 1);
    row(0, 0, 8'h00, 16'h1234, 1, 0, 1);
    // bad checksum
    row(1, 1, 8'h34, 16'h1234, 1, 0, 1);
    row(1, 0, 8'h12, 16'h1234, 1, 0, 1);
    row(1, 0, 8'h00, 16'h1234, 1, 1, 1);
    // stray beat in IDLE is silent
    row(1, 0, 8'h77, 16'h1234, 1, 1, 1);
    // sof inside RECV restarts
    row(1, 1, 8'h34, 16'h1234, 1, 1, 1);
    row(1, 1, 8'hAA, 16'h1234, 1, 2, 1);
    row(1, 0, 8'h55, 16'h1234, 1, 2, 1);
    row(1, 0, 8'hFF, 16'h55AA, 1, 2, 2);
    // sof inside CSUM restarts
    row(1, 1, 8'h34, 16'h55AA, 1, 2, 2);
    row(1, 0, 8'h12, 16'h55AA, 1, 2, 2);
    row(1, 1, 8'hEF, 16'h55AA, 1, 3, 2);
    row(1, 0, 8'hBE, 16'h55AA, 1, 3, 2);
    row(1, 0, 8'h51, 16'hBEEF, 1, 3, 3);
    // timeout in RECV after 16 idle cycles
    row(1, 1, 8'h34, 16'hBEEF, 1, 3, 3);
    idle(15, 16'hBEEF, 1, 3, 3);
    row(0, 0, 8'h00, 16'hBEEF, 1, 4, 3);
    row(1, 0, 8'h12, 16'hBEEF, 1, 4, 3);
    row(1, 0, 8'h26, 16'hBEEF, 1, 4, 3);
    // 15-cycle gaps are tolerated
    row(1, 1, 8'h34, 16'hBEEF, 1, 4, 3);
    idle(15, 16'hBEEF, 1, 4, 3);
    row(1, 0, 8'h12, 16'hBEEF, 1, 4, 3);
    idle(15, 16'hBEEF, 1, 4, 3);
    row(1, 0, 8'h26, 16'h1234, 1, 4, 4);
    // timeout while waiting for checksum
    row(1, 1, 8'h34, 16'h1234, 1, 4, 4);
    row(1, 0, 8'h12, 16'h1234, 1, 4, 4);
    idle(15, 16'h1234, 1, 4, 4);
    row(0, 0, 8'h00, 16'h1234, 1, 5, 4);
    row(1, 0, 8'h26, 16'h1234, 1, 5, 4);

    foreach (tbl[i]) begin
      beat(tbl[i].v, tbl[i].s, tbl[i].d);
      chk_all($sformatf("row%0d", i), tbl[i].dg, tbl[i].dv,
              tbl[i].e, tbl[i].f);
    end

    // err_count saturation
    for (int i = 0; i < 250; i++)
      frame(8'h34, 8'h12, 8'h00);
    chk("err_at_255", 32'(err_count), 32'd255);
    frame(8'h34, 8'h12, 8'h00);
    chk("err_saturate", 32'(err_count), 32'd255);
    chk("fc_unchanged", 32'(frame_count), 32'd4);

    // frame_count wrap
    for (int i = 0; i < 251; i++)
      frame(8'h34, 8'h12, 8'h26);
    chk("fc_at_255", 32'(frame_count), 32'd255);
    frame(8'h34, 8'h12, 8'h26);
    chk_all("fc_wrap", 16'h1234, 1'b1, 8'd255, 8'd0);
`else
    frame(8'h34, 8'h12, 8'h26);
    chk_all("pend1", 16'h0000, 1'b0, 8'd0, 8'd0);
    frame(8'hEF, 8'hBE, 8'h51);
    chk_all("pend2", 16'h0000, 1'b0, 8'd0, 8'd0);
    commit_pulse();
    chk_all("vblank1", 16'hBEEF, 1'b1, 8'd0, 8'd1);
    frame(8'hAA, 8'h55, 8'hFF);
    chk_all("pend3", 16'hBEEF, 1'b1, 8'd0, 8'd1);
    beat(1'b1, 1'b1, 8'h34);
    beat(1'b1, 1'b0, 8'h12);
    @(negedge clk);
    link_valid   = 1'b1;
    link_data    = 8'h26;
    frame_commit = 1'b1;
    @(posedge clk);
    #1;
    link_valid   = 1'b0;
    frame_commit = 1'b0;
    chk_all("same_cycle", 16'h55AA, 1'b1, 8'd0, 8'd2);
    commit_pulse();
    chk_all("vblank2", 16'h1234, 1'b1, 8'd0, 8'd3);
    commit_pulse();
    chk_all("no_pend", 16'h1234, 1'b1, 8'd0, 8'd3);
`endif

    // asynchronous reset mid-frame
    beat(1'b1, 1'b1, 8'h34);
    #3;
    rst = 1'b0;
    #2;
    chk_all("async_rst", 16'h0, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    frame(8'hEF, 8'hBE, 8'h51);
`ifdef DATAGRAM_RX_VBLANK_COMMIT_EN
    commit_pulse();
`endif
    chk_all("post_rst", 16'hBEEF, 1'b1, 8'd0, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
